// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, port owner encoding
// and the width of the read-latency counter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  localparam int LAT_W = 4;

endpackage

// File: rtl/mem_arb_picker.sv
// Grant selection between the CPU and debug ports. With MEM_ARB_RR_EN defined a
// tie goes to the port not served last; otherwise debug always wins a tie.
module mem_arb_picker
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic   clk,
  input  logic   reset,
  input  logic   take,
`endif
  input  logic   c_req,
  input  logic   d_req,
  output owner_t winner
);

`ifdef MEM_ARB_RR_EN
  owner_t last_r;

  // Tie-break against the most recent grantee; a lone request always wins
  always_comb begin
    winner = OWN_CPU;
    if (c_req && d_req) begin
      winner = (last_r == OWN_CPU) ? OWN_DBG : OWN_CPU;
    end else if (d_req) begin
      winner = OWN_DBG;
    end else begin
      winner = OWN_CPU;
    end
  end

  // Pointer starts as "CPU served last" and follows every grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_r <= OWN_CPU;
    end else if (take) begin
      last_r <= winner;
    end
  end
`else
  // Fixed priority: the loader keeps the core in reset while it owns memory
  always_comb begin
    winner = OWN_CPU;
    if (d_req) begin
      winner = OWN_DBG;
    end else begin
      winner = OWN_CPU;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Sequencer/arbiter for the shared MIPS instruction/data memory port: one timed
// access per grant, fixed read latency, one-cycle ack. Option: MEM_ARB_RR_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LATENCY = 1
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy,
  output logic          owner
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_lat_chk
    $error("mem_arbiter: LATENCY must be within 1..15");
  end

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);

  state_t           state_r;
  owner_t           owner_r;
  owner_t           win_s;
  logic [LAT_W-1:0] cnt_r;
  logic             tx_we_r;
  logic             any_req_s;
  logic             sel_we_s;
  logic [AW-1:0]    sel_addr_s;
  logic [DW-1:0]    sel_wdata_s;
  logic [DW-1:0]    rdata_r;
  logic             c_ack_r;
  logic             d_ack_r;
  logic             m_en_r;
  logic             m_we_r;
  logic [AW-1:0]    m_addr_r;
  logic [DW-1:0]    m_wdata_r;
  logic             busy_r;

  assign any_req_s = c_req | d_req;

`ifdef MEM_ARB_RR_EN
  logic take_s;
  assign take_s = (state_r == IDLE) && any_req_s;
`endif

  mem_arb_picker u_picker (
`ifdef MEM_ARB_RR_EN
    .clk    (clk),
    .reset  (reset),
    .take   (take_s),
`endif
    .c_req  (c_req),
    .d_req  (d_req),
    .winner (win_s)
  );

  // Request fields of the winning port
  always_comb begin
    sel_we_s    = c_we;
    sel_addr_s  = c_addr;
    sel_wdata_s = c_wdata;
    if (win_s == OWN_DBG) begin
      sel_we_s    = d_we;
      sel_addr_s  = d_addr;
      sel_wdata_s = d_wdata;
    end else begin
      sel_we_s    = c_we;
      sel_addr_s  = c_addr;
      sel_wdata_s = c_wdata;
    end
  end

  // Transaction FSM; every output is a register loaded on the transition into its state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      owner_r   <= OWN_CPU;
      cnt_r     <= {LAT_W{1'b0}};
      tx_we_r   <= 1'b0;
      rdata_r   <= {DW{1'b0}};
      c_ack_r   <= 1'b0;
      d_ack_r   <= 1'b0;
      m_en_r    <= 1'b0;
      m_we_r    <= 1'b0;
      m_addr_r  <= {AW{1'b0}};
      m_wdata_r <= {DW{1'b0}};
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            state_r   <= ISSUE;
            owner_r   <= win_s;
            tx_we_r   <= sel_we_s;
            m_en_r    <= 1'b1;
            m_we_r    <= sel_we_s;
            m_addr_r  <= sel_addr_s;
            m_wdata_r <= sel_wdata_s;
            busy_r    <= 1'b1;
          end else begin
            state_r   <= IDLE;
          end
        end
        ISSUE: begin
          state_r <= WAIT;
          cnt_r   <= LAT_LOAD;
          m_en_r  <= 1'b0;
          m_we_r  <= 1'b0;
        end
        WAIT: begin
          if (cnt_r == {LAT_W{1'b0}}) begin
            state_r <= RESP;
            c_ack_r <= (owner_r == OWN_CPU);
            d_ack_r <= (owner_r == OWN_DBG);
            if (!tx_we_r) begin
              rdata_r <= m_rdata;
            end
          end else begin
            cnt_r <= cnt_r - LAT_W'(1);
          end
        end
        RESP: begin
          state_r <= IDLE;
          c_ack_r <= 1'b0;
          d_ack_r <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          c_ack_r <= 1'b0;
          d_ack_r <= 1'b0;
          m_en_r  <= 1'b0;
          m_we_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign c_ack   = c_ack_r;
  assign d_ack   = d_ack_r;
  assign c_rdata = rdata_r;
  assign d_rdata = rdata_r;
  assign m_en    = m_en_r;
  assign m_we    = m_we_r;
  assign m_addr  = m_addr_r;
  assign m_wdata = m_wdata_r;
  assign busy    = busy_r;
  assign owner   = owner_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two lanes (LATENCY 1 and 3) under identical directed
// traffic, a cycle-number transaction model per lane, plus literal spot checks.
module tb_mem_arbiter;

  localparam int NL    = 2;
  localparam int DEPTH = 256;
  localparam int TMO   = 500;
`ifdef MEM_ARB_RR_EN
  localparam logic [7:0] EXP_ORDER = 8'b1010_1010;
`else
  localparam logic [7:0] EXP_ORDER = 8'b1111_0000;
`endif

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // pending requests per lane, memory contents, and observation logs
  txn_t        cq [NL][$];
  txn_t        dq [NL][$];
  logic [31:0] bmem [NL][DEPTH];
  logic [31:0] rmem [NL][DEPTH];
  int          present_c [NL];
  int          cack_cnt [NL];
  int          dack_cnt [NL];
  int          last_ack_cyc [NL];
  logic [31:0] last_ack_data [NL];
  logic [7:0]  ack_order [NL];
  int          men_cyc [NL][$];
  logic [31:0] men_addr [NL][$];
  logic        men_we [NL][$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  for (genvar k = 0; k < NL; k++) begin : g_lane
    localparam int L = (k == 0) ? 1 : 3;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_ack, d_ack, m_en, m_we, busy, owner;
    logic [31:0] c_rdata, d_rdata, m_addr, m_wdata, m_rdata;

    mem_arbiter #(.AW(32), .DW(32), .LATENCY(L)) u_dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_ack(c_ack), .c_rdata(c_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .busy(busy), .owner(owner)
    );

    // requesters: present queue head, hold until ack, keep req high if more queued
    initial begin : bfm
      logic ca, da;
      c_req = 1'b0; c_we = 1'b0; c_addr = 32'h0; c_wdata = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
      forever begin
        @(negedge clk);
        ca = c_ack;
        da = d_ack;
        @(posedge clk);
        #1;
        if (c_req && ca) cq[k].delete(0);
        if (cq[k].size() > 0) begin
          if (!c_req || ca) present_c[k] = cyc;
          c_req = 1'b1; c_we = cq[k][0].we; c_addr = cq[k][0].addr; c_wdata = cq[k][0].wdata;
        end else begin
          c_req = 1'b0;
        end
        if (d_req && da) dq[k].delete(0);
        if (dq[k].size() > 0) begin
          d_req = 1'b1; d_we = dq[k][0].we; d_addr = dq[k][0].addr; d_wdata = dq[k][0].wdata;
        end else begin
          d_req = 1'b0;
        end
      end
    end

    // memory: writes land on the strobe, read data valid exactly L cycles after it
    initial begin : memory
      int          rd_due;
      logic [31:0] rd_val;
      rd_due  = -1;
      rd_val  = 32'h0;
      m_rdata = 32'hBAD0_BAD0;
      forever begin
        @(negedge clk);
        if (m_en) begin
          if (m_we) begin
            bmem[k][m_addr[9:2]] = m_wdata;
          end else begin
            rd_due = cyc + L;
            rd_val = bmem[k][m_addr[9:2]];
          end
        end
        @(posedge clk);
        #1;
        m_rdata = (cyc == rd_due) ? rd_val : 32'hBAD0_BAD0;
      end
    end

    // model: a grant in idle cycle g gives strobe at g+1, ack at g+L+2, next grant after that
    initial begin : model
      int          g, n;
      logic        t_own, t_we, last_srv, e_own, e_en, e_busy, e_cack, e_dack;
      logic [31:0] t_addr, t_wdata, e_rdata;
      string       p;
      g = -1000; t_own = 1'b0; t_we = 1'b0; t_addr = 32'h0; t_wdata = 32'h0;
      last_srv = 1'b0; e_own = 1'b0; e_rdata = 32'h0;
      p = $sformatf("L%0d_", L);
      forever begin
        @(negedge clk);
        n = cyc;
        if (reset) begin
          g = -1000; last_srv = 1'b0; e_own = 1'b0; e_rdata = 32'h0;
          chk({p, "rst_busy"}, {31'b0, busy}, 32'd0);
          chk({p, "rst_m_en"}, {31'b0, m_en}, 32'd0);
          chk({p, "rst_m_we"}, {31'b0, m_we}, 32'd0);
          chk({p, "rst_acks"}, {30'b0, c_ack, d_ack}, 32'd0);
          chk({p, "rst_owner"}, {31'b0, owner}, 32'd0);
          chk({p, "rst_m_addr"}, m_addr, 32'd0);
          chk({p, "rst_m_wdata"}, m_wdata, 32'd0);
          chk({p, "rst_rdata"}, c_rdata, 32'd0);
        end else begin
          e_en   = (n == g + 1);
          e_busy = (n >= g + 1) && (n <= g + L + 2);
          e_cack = (n == g + L + 2) && !t_own;
          e_dack = (n == g + L + 2) && t_own;
          if (e_en) begin
            e_own = t_own;
            if (t_we) rmem[k][t_addr[9:2]] = t_wdata;
          end
          if ((n == g + L + 2) && !t_we) e_rdata = rmem[k][t_addr[9:2]];
          chk({p, "busy"}, {31'b0, busy}, {31'b0, e_busy});
          chk({p, "m_en"}, {31'b0, m_en}, {31'b0, e_en});
          chk({p, "c_ack"}, {31'b0, c_ack}, {31'b0, e_cack});
          chk({p, "d_ack"}, {31'b0, d_ack}, {31'b0, e_dack});
          chk({p, "owner"}, {31'b0, owner}, {31'b0, e_own});
          chk({p, "c_rdata"}, c_rdata, e_rdata);
          chk({p, "d_rdata"}, d_rdata, e_rdata);
          if (e_en) begin
            chk({p, "m_we"}, {31'b0, m_we}, {31'b0, t_we});
            chk({p, "m_addr"}, m_addr, t_addr);
            if (t_we) chk({p, "m_wdata"}, m_wdata, t_wdata);
          end
          if (m_en) begin
            men_cyc[k].push_back(n);
            men_addr[k].push_back(m_addr);
            men_we[k].push_back(m_we);
          end
          if (c_ack || d_ack) begin
            last_ack_cyc[k]  = n;
            last_ack_data[k] = c_ack ? c_rdata : d_rdata;
            ack_order[k]     = {ack_order[k][6:0], d_ack};
            if (c_ack) cack_cnt[k]++;
            if (d_ack) dack_cnt[k]++;
          end
          if ((n > g + L + 2) && (c_req || d_req)) begin
`ifdef MEM_ARB_RR_EN
            t_own = (c_req && d_req) ? ~last_srv : d_req;
            last_srv = t_own;
`else
            t_own = d_req;
`endif
            g       = n;
            t_we    = t_own ? d_we : c_we;
            t_addr  = t_own ? d_addr : c_addr;
            t_wdata = t_own ? d_wdata : c_wdata;
          end
        end
      end
    end
  end

  task automatic clear_logs();
    for (int i = 0; i < NL; i++) begin
      cack_cnt[i] = 0; dack_cnt[i] = 0; ack_order[i] = 8'h00;
      men_cyc[i].delete(); men_addr[i].delete(); men_we[i].delete();
    end
  endtask

  task automatic push_c(input logic we, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < NL; i++) cq[i].push_back('{we, a, wd});
  endtask

  task automatic push_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < NL; i++) dq[i].push_back('{we, a, wd});
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (t < TMO && (cq[0].size() != 0 || cq[1].size() != 0 ||
               dq[0].size() != 0 || dq[1].size() != 0 ||
               g_lane[0].c_req || g_lane[0].d_req || g_lane[1].c_req || g_lane[1].d_req ||
               g_lane[0].busy || g_lane[1].busy));
    chk({nm, "_done"}, (t < TMO) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat_exp [NL];
    lat_exp[0] = 3;
    lat_exp[1] = 5;
    for (int i = 0; i < NL; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        bmem[i][j] = 32'hA500_0000 | j;
        rmem[i][j] = 32'hA500_0000 | j;
      end
      bmem[i][16] = 32'h1234_ABCD;
      rmem[i][16] = 32'h1234_ABCD;
      present_c[i] = 0;
      last_ack_cyc[i] = 0;
      last_ack_data[i] = 32'h0;
    end
    clear_logs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'b0, g_lane[0].busy}, 32'd0);
    chk("reset_c_rdata", g_lane[1].c_rdata, 32'd0);
    #2 reset = 1'b0;

    // CPU read of 0x40
    @(negedge clk);
    clear_logs();
    push_c(1'b0, 32'h40, 32'h0);
    wait_idle("t1");
    for (int i = 0; i < NL; i++) begin
      chk($sformatf("t1_L%0d_men_lat", i), men_cyc[i][0] - present_c[i], 32'd1);
      chk($sformatf("t1_L%0d_ack_lat", i), last_ack_cyc[i] - present_c[i], lat_exp[i]);
      chk($sformatf("t1_L%0d_data", i), last_ack_data[i], 32'h1234_ABCD);
      chk($sformatf("t1_L%0d_dacks", i), dack_cnt[i], 32'd0);
    end

    // debug write 0xDEADBEEF to 0x80, then CPU read back
    clear_logs();
    push_d(1'b1, 32'h80, 32'hDEAD_BEEF);
    wait_idle("t2w");
    for (int i = 0; i < NL; i++) begin
      chk($sformatf("t2_L%0d_wstrobe_we", i), {31'b0, men_we[i][0]}, 32'd1);
      chk($sformatf("t2_L%0d_wstrobe_addr", i), men_addr[i][0], 32'h80);
    end
    clear_logs();
    push_c(1'b0, 32'h80, 32'h0);
    wait_idle("t2r");
    for (int i = 0; i < NL; i++) begin
      chk($sformatf("t2_L%0d_ack_lat", i), last_ack_cyc[i] - present_c[i], lat_exp[i]);
      chk($sformatf("t2_L%0d_data", i), last_ack_data[i], 32'hDEAD_BEEF);
    end

    // both ports raised together, four transactions each
    clear_logs();
    for (int j = 0; j < 4; j++) begin
      push_c(1'b0, 32'h100 + 4 * j, 32'h0);
      push_d(1'b0, 32'h200 + 4 * j, 32'h0);
    end
    wait_idle("t3");
    for (int i = 0; i < NL; i++) begin
      chk($sformatf("t3_L%0d_order", i), {24'b0, ack_order[i]}, {24'b0, EXP_ORDER});
      chk($sformatf("t3_L%0d_cacks", i), cack_cnt[i], 32'd4);
    end

    // reset during WAIT of a CPU read, then the held request completes
    clear_logs();
    push_c(1'b0, 32'h40, 32'h0);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NL; i++) chk($sformatf("t4_L%0d_no_ack", i), cack_cnt[i], 32'd0);
    chk("t4_L0_busy_after", {31'b0, g_lane[0].busy}, 32'd0);
    chk("t4_L1_m_en_after", {31'b0, g_lane[1].m_en}, 32'd0);
    wait_idle("t4");
    for (int i = 0; i < NL; i++) begin
      chk($sformatf("t4_L%0d_reissue", i), cack_cnt[i], 32'd1);
      chk($sformatf("t4_L%0d_data", i), last_ack_data[i], 32'h1234_ABCD);
    end

    // CPU req held across its ack with a new address
    clear_logs();
    push_c(1'b0, 32'h44, 32'h0);
    push_c(1'b0, 32'h48, 32'h0);
    wait_idle("t5");
    for (int i = 0; i < NL; i++) begin
      chk($sformatf("t5_L%0d_spacing", i), men_cyc[i][1] - men_cyc[i][0], lat_exp[i] + 1);
      chk($sformatf("t5_L%0d_addr2", i), men_addr[i][1], 32'h48);
      chk($sformatf("t5_L%0d_data2", i), last_ack_data[i], 32'hA500_0012);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter for the single unified instruction/data memory of the multi-cycle MIPS core. It shares the one memory port between two requesters: the CPU port, which the core controller uses for fetch and load/store, and a debug/loader port used for program preload and memory inspection. It converts each granted request into one timed memory access with a fixed read latency. It returns a one-cycle acknowledge that the core controller uses to hold its current state.

## Interface
- AW, 32, address width
- DW, 32, data width
- LATENCY, 1, memory read latency in cycles (1..15): m_rdata is valid exactly LATENCY cycles after the cycle with m_en=1
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- c_req / d_req  input  1  CPU / debug access request, level
- c_we / d_we  input  1  write when 1, read when 0
- c_addr / d_addr  input  AW  byte address
- c_wdata / d_wdata  input  DW  write data
- c_ack / d_ack  output  1  one-cycle completion pulse
- c_rdata / d_rdata  output  DW  read data; both driven from one shared register; valid in the ack cycle
- m_en  output  1  memory access strobe, one cycle per transaction
- m_we  output  1  memory write enable, qualified by m_en
- m_addr  output  AW  memory address
- m_wdata  output  DW  memory write data
- m_rdata  input  DW  memory read data
- busy  output  1  1 in every state except IDLE
- owner  output  1  0 = CPU, 1 = debug; current or last grantee

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req=1: select a winner, latch its we/addr/wdata into the transaction registers, set owner, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: m_en=1. m_we, m_addr and m_wdata come from the latched registers. Load the counter with LATENCY-1 and go to WAIT.
- WAIT:
  - Hold for LATENCY cycles; the counter decrements each cycle.
  - In the last WAIT cycle on a read, capture m_rdata into the rdata register.
  - On a write, rdata keeps its previous value.
- RESP: assert the ack for the owner only. Go to IDLE.
- Requester rules:
  - Hold req and its request fields stable until its ack is sampled.
  - Fields are latched in IDLE, so later changes do not affect the access in flight.
  - A requester that keeps req high across its ack issues a new request. That request is arbitrated in the following IDLE cycle.
- Default arbitration: the debug port has fixed priority over the CPU. The loader holds the core in reset during preload, so CPU starvation is acceptable.
- m_addr and m_wdata hold their last values outside ISSUE. Memory ignores them while m_en=0.

## Timing
- Reset values: state=IDLE; c_ack=d_ack=0; m_en=m_we=0; m_addr, m_wdata and rdata = 0; owner=0; busy=0. The round-robin pointer resets to "CPU last served".
- Latency from the cycle req is seen in IDLE to the ack cycle: LATENCY+2 cycles. With LATENCY=1 this is 3.
- Throughput: one transaction per LATENCY+3 cycles, because of the mandatory IDLE cycle between transactions.
- Both requests asserted in the same IDLE cycle: exactly one is granted. The other waits, with no ack and no loss of its request.
- A req that drops before it is granted is never served. A req that drops after grant still completes, and the ack is still pulsed.
- Reset asserted mid-transaction: immediate return to IDLE, all outputs take their reset values, and no ack is issued.
  - A write already strobed by m_en stays in memory.
  - The aborted requester must re-request.
- LATENCY outside 1..15: elaboration error.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - On simultaneous requests, grant the port not served last.
  - The pointer updates on each grant.
  - A lone request is always granted.
- MEM_ARB_RR_EN undefined: fixed debug-over-CPU priority. The pointer register is not built.

## Structure
- Package mem_arb_pkg holds:
  - state enum: IDLE, ISSUE, WAIT, RESP
  - owner enum: OWN_CPU=0, OWN_DBG=1
  - LAT_W=4 counter width constant
- Sub-module mem_arb_picker: combinational grant selection, plus the round-robin pointer register under MEM_ARB_RR_EN. Inputs are c_req and d_req; it outputs the winner. The FSM, counter and datapath registers stay in mem_arbiter.

## Test plan
- CPU read only, LATENCY=1, mem[0x40]=0x1234ABCD, c_req with addr 0x40: m_en is pulsed at cycle 1, c_ack at cycle 3 with c_rdata=0x1234ABCD, d_ack stays 0.
- Debug write 0xDEADBEEF to 0x80, then CPU read of 0x80, LATENCY=3: the write strobe has m_we=1. The read returns 0xDEADBEEF with ack 5 cycles after the request is seen.
- c_req and d_req raised in the same cycle, each held for 4 transactions:
  - Default build: all 4 debug transactions are served before any CPU transaction.
  - MEM_ARB_RR_EN: grants alternate D, C, D, C.
- Reset pulsed during WAIT of a CPU read: no ack is issued; busy=0 and m_en=0 in the cycle after reset. A re-request then completes normally.
- c_req held high across its ack with a changed address: a second transaction is issued with the new address, and m_en pulses are separated by LATENCY+3 cycles.
